param_report_tx: RTL
====================

Name: param_report_tx

Overview:
Hardware counterpart of a simulation-time parameter report: serialises a fixed label and a W-bit unsigned value into an ASCII byte stream "<STR> = <decimal>\n".
Feeds a byte sink (UART/trace FIFO) over a valid/ready interface.
Lets synthesised designs emit the same "%s ... = %0d" lines that testbenches print with $display.

Parameters:
STR_LEN, 1, label length in characters; 0 is legal and emits no label bytes.
STR, "t", label, packed 8*STR_LEN bits, first character in the most significant byte.
W, 32, value width in bits; 1..64.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  request a report; sampled only in IDLE
value  input  W  unsigned value, latched on start acceptance
busy  output  1  high from start acceptance until the final byte transfers
out_data  output  8  ASCII byte
out_valid  output  1  out_data valid
out_ready  input  1  sink accepts the byte
done  output  1  one-cycle pulse in the cycle after the newline byte transfers

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: busy=0, out_valid=0, out_data=8'h00, done=0, state=IDLE. All state clears, including mid-report; no partial line resumes after reset.
- Handshake:
  - A transfer occurs on a rising edge with out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data holds stable and out_valid stays high.
  - out_valid never depends combinationally on out_ready.
- start is accepted only in IDLE. In any other state it is ignored, with no queueing.
- States:
  - IDLE -> CONV on start accepted: latch value, set busy.
  - CONV: double-dabble binary-to-BCD, exactly W cycles, one bit per cycle, MSB first. After W cycles -> LABEL, or -> SEP when STR_LEN=0.
  - LABEL: emit STR bytes MSB first, one per transfer. After STR_LEN transfers -> SEP.
  - SEP: emit 8'h20, 8'h3D, 8'h20 (" = ") -> DIGITS.
  - DIGITS: emit BCD digits most significant first as 8'h30+digit.
    - Leading zeros are suppressed.
    - Value 0 emits a single 8'h30.
    - After the least-significant digit -> NL.
  - NL: emit 8'h0A. On transfer -> IDLE, clear busy, pulse done.
- Latency:
  - Start accepted at edge 0; out_valid first rises after edge W.
  - With out_ready tied high, one byte transfers per cycle, with no bubbles between states.
  - busy falls at the same edge the newline transfers.
- Widths:
  - D = number of BCD digits = floor(W*30103/100000)+1. W=8 gives D=3; W=32 gives D=10.
  - The BCD register is 4*D bits; double-dabble adds 3 to any nibble >=5 before each shift.
  - The leading-zero search scans from the most significant nibble; the digit index is a clog2(D+1)-bit counter.
- Boundaries:
  - The all-ones value must emit every digit, e.g. 4294967295 for W=32.
  - W=1 emits "0" or "1".
  - A start pulse coincident with the final NL transfer is ignored; the state is not yet IDLE.
  - Reset asserted while out_valid=1 drops out_valid immediately (asynchronous).

Decomposition:
- Shared package param_report_pkg holds:
  - ASCII constants: ASCII_SP=8'h20, ASCII_EQ=8'h3D, ASCII_0=8'h30, ASCII_NL=8'h0A.
  - The state enum typedef report_state_t: IDLE, CONV, LABEL, SEP, DIGITS, NL.
  - The function bcd_digits(W) returning D.
- One sub-module: bin2bcd_seq, parameterised by W.
  - Ports: clk, rst, load, bin[W-1:0], bcd[4*D-1:0], ready.
  - Implements the W-cycle double-dabble.
- The top module holds the FSM, the byte mux and the handshake.

Test Plan:
- STR="w", STR_LEN=1, W=8, value=8, out_ready=1 -> bytes 77 20 3D 20 38 0A. out_valid first high after edge 8. done pulses once.
- STR="v", W=16, value=16, out_ready toggled with a 50% random pattern -> exactly 76 20 3D 20 31 36 0A. Every stall holds out_data stable, with no drop or duplicate.
- STR_LEN=0, W=32, value=32'hFFFFFFFF -> 20 3D 20 34 32 39 34 39 36 37 32 39 35 0A (13 bytes of " = 4294967295", then newline); busy high throughout.
- W=32, value=0 -> label, " = ", single 30, 0A. No leading-zero bytes.
- Second start pulsed during DIGITS -> ignored; exactly one line is emitted, and a start after done begins a new report.
- rst asserted mid-LABEL -> out_valid, busy and done go 0 asynchronously. After release with no start, no bytes; a new start produces a complete correct line.

Source files
------------

// File: rtl/param_report_pkg.sv
`default_nettype none
// ============================================================================
// Module   : param_report_pkg
// Purpose  : Shared ASCII constants, FSM state type and BCD sizing helper.
// Revision : 1.0
// ============================================================================
package param_report_pkg;

    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_EQ = 8'h3D;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_NL = 8'h0A;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONV   = 3'd1,
        LABEL  = 3'd2,
        SEP    = 3'd3,
        DIGITS = 3'd4,
        NL     = 3'd5
    } report_state_t;

    // Decimal digits needed for a w-bit unsigned value (log10(2) ~ 0.30103).
    function automatic int bcd_digits(input int w);
        return (w * 30103) / 100000 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/param_report_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : param_report_tx_if
// Purpose  : Valid/ready byte stream from the report serialiser to its sink.
// Revision : 1.0
// ============================================================================
interface param_report_tx_if;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential double-dabble, one input bit per cycle, MSB first.
// Revision : 1.0
// ============================================================================
module bin2bcd_seq
    import param_report_pkg::*;
#(
    parameter  int W = 32,
    localparam int D = bcd_digits(W)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           load,
    input  wire logic [W-1:0]   bin,
    output logic [4*D-1:0]      bcd,
    output logic                ready
);

    localparam int c_CNT_W = $clog2(W + 1);

    logic [W-1:0]       r_shift;
    logic [c_CNT_W-1:0] r_cnt;
    logic [4*D-1:0]     r_bcd;
    logic [4*D-1:0]     w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < D; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
        end else if (load) begin
            r_shift <= bin;
            r_bcd   <= '0;
            r_cnt   <= c_CNT_W'(W);
        end else if (r_cnt != '0) begin
            r_bcd   <= {w_adj[4*D-2:0], r_shift[W-1]};
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt - 1'b1;
        end
    end

    assign bcd   = r_bcd;
    // High during the final shift cycle; bcd is complete from the next cycle.
    assign ready = (r_cnt == c_CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/param_report_tx.sv
`default_nettype none
// ============================================================================
// Module   : param_report_tx
// Purpose  : Serialises "<STR> = <decimal>\n" for a latched W-bit value.
// Revision : 1.0
// ============================================================================
module param_report_tx
    import param_report_pkg::*;
#(
    parameter int                                   STR_LEN = 1,
    parameter logic [8*((STR_LEN > 0) ? STR_LEN : 1)-1:0] STR = "t",
    parameter int                                   W       = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          start,
    input  wire logic [W-1:0]  value,
    output logic               busy,
    output logic               done,
    param_report_tx_if.master  tx
);

    localparam int c_SL    = (STR_LEN > 0) ? STR_LEN : 1;
    localparam int c_D     = bcd_digits(W);
    localparam int c_DIG_W = $clog2(c_D + 1);
    localparam int c_IDX_W = $clog2(((c_SL > 3) ? c_SL : 3) + 1);
    localparam logic [c_IDX_W-1:0] c_LABEL_LAST = c_IDX_W'(c_SL - 1);

    report_state_t      r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_valid;
    logic [7:0]         r_data;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_DIG_W-1:0] r_dig;

    logic [4*c_D-1:0]   w_bcd;
    logic               w_conv_last;
    logic               w_load;
    logic               w_xfer;
    logic [c_DIG_W-1:0] w_first;

    assign w_load = (r_state == IDLE) && start;
    assign w_xfer = r_valid && tx.out_ready;

    bin2bcd_seq #(
        .W (W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .bin   (value),
        .bcd   (w_bcd),
        .ready (w_conv_last)
    );

    // Most significant non-zero nibble; an all-zero value still yields digit 0.
    always_comb begin
        w_first = '0;
        for (int k = 0; k < c_D; k++) begin
            if (w_bcd[4*k +: 4] != 4'd0) begin
                w_first = c_DIG_W'(k);
            end
        end
    end

    function automatic logic [7:0] label_byte(input logic [c_IDX_W-1:0] i);
        return 8'(STR >> (8 * (c_SL - 1 - int'(i))));
    endfunction

    function automatic logic [7:0] digit_char(input logic [c_DIG_W-1:0] k);
        return ASCII_0 + {4'h0, 4'(w_bcd >> (4 * int'(k)))};
    endfunction

    // Each state preloads the next byte on a transfer, so the stream has no bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= 8'h00;
            r_idx   <= '0;
            r_dig   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= CONV;
                        r_busy  <= 1'b1;
                    end
                end
                CONV: begin
                    if (w_conv_last) begin
                        r_valid <= 1'b1;
                        r_idx   <= '0;
                        if (STR_LEN == 0) begin
                            r_state <= SEP;
                            r_data  <= ASCII_SP;
                        end else begin
                            r_state <= LABEL;
                            r_data  <= label_byte('0);
                        end
                    end
                end
                LABEL: begin
                    if (w_xfer) begin
                        if (r_idx == c_LABEL_LAST) begin
                            r_state <= SEP;
                            r_data  <= ASCII_SP;
                            r_idx   <= '0;
                        end else begin
                            r_data  <= label_byte(r_idx + 1'b1);
                            r_idx   <= r_idx + 1'b1;
                        end
                    end
                end
                SEP: begin
                    if (w_xfer) begin
                        if (r_idx == c_IDX_W'(0)) begin
                            r_data <= ASCII_EQ;
                            r_idx  <= r_idx + 1'b1;
                        end else if (r_idx == c_IDX_W'(1)) begin
                            r_data <= ASCII_SP;
                            r_idx  <= r_idx + 1'b1;
                        end else begin
                            r_state <= DIGITS;
                            r_data  <= digit_char(w_first);
                            r_dig   <= w_first;
                        end
                    end
                end
                DIGITS: begin
                    if (w_xfer) begin
                        if (r_dig == '0) begin
                            r_state <= NL;
                            r_data  <= ASCII_NL;
                        end else begin
                            r_data  <= digit_char(r_dig - 1'b1);
                            r_dig   <= r_dig - 1'b1;
                        end
                    end
                end
                NL: begin
                    if (w_xfer) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_data  <= 8'h00;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign tx.out_data  = r_data;
    assign tx.out_valid = r_valid;

endmodule
`default_nettype wire
